// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: walks the PC/MAR/memory strobes, captures the fetched word into IR
// and hands it to decode over valid/ready. Optional single-step mode enabled by FETCH_STEP_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module fetch_sequencer #(
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef FETCH_STEP_EN
  input  logic                  step,
`endif
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  run,
  output logic                  pc_cs,
  output logic                  pc_oe,
  output logic                  pc_en,
  output logic                  pc_cnt_en,
  output logic                  mar_en,
  output logic                  mem_cs,
  output logic                  mem_oe,
  output logic [DATA_WIDTH-1:0] ir,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  input  logic                  jump_req,
  input  logic [DATA_WIDTH-1:0] jump_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_MEM,
    S_INC,
    S_HOLD,
    S_JUMP
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

  state_t                state_q, state_d;
  logic [3:0]            wait_q, wait_d;
  logic [DATA_WIDTH-1:0] ir_q;
  logic [DATA_WIDTH-1:0] jaddr_q;
  logic                  pc_cs_q, pc_oe_q, pc_en_q, pc_cnt_en_q;
  logic                  mar_en_q, mem_cs_q, mem_oe_q, ir_valid_q;
  logic                  bus_drive_q;
  logic                  fetch_start;
  logic                  resume;
  logic                  capture;
  logic                  handshake;

`ifdef FETCH_STEP_EN
  logic step_q;
  // One fetch per rising edge of step; after each instruction the sequencer parks in IDLE.
  assign fetch_start = step && !step_q;
  assign resume      = 1'b0;
`else
  assign fetch_start = run;
  assign resume      = run;
`endif

  assign capture   = (state_q == S_MEM) && (wait_q == WAIT_LAST);
  assign handshake = (state_q == S_HOLD) && ir_ready;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: if (fetch_start) state_d = S_ADDR;
      S_ADDR: begin
        state_d = S_MEM;
        wait_d  = '0;
      end
      S_MEM: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_INC;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_INC:  state_d = S_HOLD;
      S_HOLD: begin
        if (ir_ready) begin
          if (jump_req)    state_d = S_JUMP;
          else if (resume) state_d = S_ADDR;
          else             state_d = S_IDLE;
        end
      end
      S_JUMP:  state_d = resume ? S_ADDR : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered copies of the decode of the next state, so they track state_q exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      ir_q        <= '0;
      jaddr_q     <= '0;
      pc_cs_q     <= 1'b0;
      pc_oe_q     <= 1'b0;
      pc_en_q     <= 1'b0;
      pc_cnt_en_q <= 1'b0;
      mar_en_q    <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
      ir_valid_q  <= 1'b0;
      bus_drive_q <= 1'b0;
`ifdef FETCH_STEP_EN
      step_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      if (capture) ir_q <= data;
      if (handshake && jump_req) jaddr_q <= jump_addr;
      pc_cs_q     <= (state_d == S_ADDR) || (state_d == S_INC) || (state_d == S_JUMP);
      pc_oe_q     <= (state_d == S_ADDR);
      pc_en_q     <= (state_d == S_JUMP);
      pc_cnt_en_q <= (state_d == S_INC);
      mar_en_q    <= (state_d == S_ADDR);
      mem_cs_q    <= (state_d == S_MEM);
      mem_oe_q    <= (state_d == S_MEM);
      ir_valid_q  <= (state_d == S_HOLD);
      bus_drive_q <= (state_d == S_JUMP);
`ifdef FETCH_STEP_EN
      step_q      <= step;
`endif
    end
  end

  assign data      = bus_drive_q ? jaddr_q : {DATA_WIDTH{1'bz}};
  assign pc_cs     = pc_cs_q;
  assign pc_oe     = pc_oe_q;
  assign pc_en     = pc_en_q;
  assign pc_cnt_en = pc_cnt_en_q;
  assign mar_en    = mar_en_q;
  assign mem_cs    = mem_cs_q;
  assign mem_oe    = mem_oe_q;
  assign ir        = ir_q;
  assign ir_valid  = ir_valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (WAIT_STATES 0 and 2) with counter/MAR/memory bus models,
// a phase-level reference model, a directed vector table and randomized traffic.
module tb_fetch_sequencer;

  localparam logic [7:0] X_IDLE = 8'b0000_0000;
  localparam logic [7:0] X_ADDR = 8'b1100_1000;
  localparam logic [7:0] X_MEM  = 8'b0000_0110;
  localparam logic [7:0] X_INC  = 8'b1001_0000;
  localparam logic [7:0] X_HOLD = 8'b0000_0001;
  localparam logic [7:0] X_JUMP = 8'b1010_0000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b1;
  logic       step = 1'b0;
  logic       ir_ready = 1'b0;
  logic       jump_req = 1'b0;
  logic [7:0] jump_addr = 8'h00;
  logic       chk_en = 1'b0;

  logic [7:0] mem [256];
  logic [7:0] strb [2];
  logic [7:0] ir_s [2];
  logic [7:0] pc_s [2];
  logic [7:0] data_s [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int inst, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d at %0t: got %02h expected %02h", name, inst, $time, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int WS = gi * 2;
    wire  [7:0] data;
    logic       pc_cs, pc_oe, pc_en, pc_cnt_en, mar_en, mem_cs, mem_oe, ir_valid;
    logic [7:0] ir;
    logic [7:0] pc_m = (gi == 0) ? 8'h00 : 8'hFF;
    logic [7:0] mar_m = 8'h00;

    // Program counter and memory share the bus with the DUT.
    assign data = (pc_cs && pc_oe) ? pc_m : ((mem_cs && mem_oe) ? mem[mar_m] : 8'bz);

    fetch_sequencer #(.DATA_WIDTH(8), .WAIT_STATES(WS)) u_dut (
      .clk(clk),
      .reset(reset),
`ifdef FETCH_STEP_EN
      .step(step),
`endif
      .data(data),
      .run(run),
      .pc_cs(pc_cs),
      .pc_oe(pc_oe),
      .pc_en(pc_en),
      .pc_cnt_en(pc_cnt_en),
      .mar_en(mar_en),
      .mem_cs(mem_cs),
      .mem_oe(mem_oe),
      .ir(ir),
      .ir_valid(ir_valid),
      .ir_ready(ir_ready),
      .jump_req(jump_req),
      .jump_addr(jump_addr)
    );

    assign strb[gi]   = {pc_cs, pc_oe, pc_en, pc_cnt_en, mar_en, mem_cs, mem_oe, ir_valid};
    assign ir_s[gi]   = ir;
    assign pc_s[gi]   = pc_m;
    assign data_s[gi] = data;

    always @(posedge clk) begin
      if (pc_cs && pc_en)          pc_m <= data;
      else if (pc_cs && pc_cnt_en) pc_m <= pc_m + 8'd1;
      if (mar_en) mar_m <= data;
    end

    // Reference: ph 0 idle, 1 fetching (cyc counts cycles since fetch start), 2 hold, 3 jump.
    int         ph = 0;
    int         cyc = 0;
    logic [7:0] m_pc = (gi == 0) ? 8'h00 : 8'hFF;
    logic [7:0] m_ir = 8'h00;
    logic [7:0] m_jaddr = 8'h00;
    logic       step_prev = 1'b0;
    logic       m_start, m_resume;

`ifdef FETCH_STEP_EN
    assign m_start  = step && !step_prev;
    assign m_resume = 1'b0;
`else
    assign m_start  = run;
    assign m_resume = run;
`endif

    always @(posedge clk or negedge reset) begin
      if (!reset) begin
        ph <= 0;
        cyc <= 0;
        m_ir <= 8'h00;
        step_prev <= 1'b0;
      end else begin
        step_prev <= step;
        case (ph)
          0: if (m_start) begin ph <= 1; cyc <= 0; end
          1: begin
            if (cyc == WS + 1) m_ir <= mem[m_pc];
            if (cyc == WS + 2) begin m_pc <= m_pc + 8'd1; ph <= 2; end
            else cyc <= cyc + 1;
          end
          2: if (ir_ready) begin
            if (jump_req) begin ph <= 3; m_jaddr <= jump_addr; end
            else if (m_resume) begin ph <= 1; cyc <= 0; end
            else ph <= 0;
          end
          default: begin
            m_pc <= m_jaddr;
            if (m_resume) begin ph <= 1; cyc <= 0; end
            else ph <= 0;
          end
        endcase
      end
    end

    function automatic logic [7:0] exp_strb(input int p, input int c);
      if (p == 0) return X_IDLE;
      if (p == 2) return X_HOLD;
      if (p == 3) return X_JUMP;
      if (c == 0) return X_ADDR;
      if (c <= WS + 1) return X_MEM;
      return X_INC;
    endfunction

    always @(negedge clk) begin
      if (chk_en) begin
        chk("strobes", gi, strb[gi], exp_strb(ph, cyc));
        chk("ir", gi, ir, m_ir);
        chk("pc", gi, pc_m, m_pc);
        chk("bus_excl", gi, 8'(int'(pc_oe) + int'(mem_oe) + int'(pc_en) <= 1), 8'd1);
        if (ph == 3) chk("jump_data", gi, data, m_jaddr);
      end
    end
  end

  typedef struct {
    logic       run;
    logic       rdy;
    logic       jreq;
    logic [7:0] jaddr;
    logic [7:0] exp_strb;
    logic       chk_ir;
    logic [7:0] exp_ir;
    logic       chk_data;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl [18];
  int   cnt_a, cnt_b, cnt_c, cnt_d;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    mem[8'h00] = 8'hBF;
    mem[8'h01] = 8'hAD;
    mem[8'h02] = 8'h3C;
    mem[8'h67] = 8'h5A;
    mem[8'hFF] = 8'hE1;

    // Backpressure on 'hAD, then a fetch ending in a jump to 'h67, then the fetch from 'h67.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, X_ADDR, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, X_MEM,  1'b0, 8'h00, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, X_INC,  1'b1, 8'hAD, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, X_HOLD, 1'b1, 8'hAD, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, X_HOLD, 1'b1, 8'hAD, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, X_HOLD, 1'b1, 8'hAD, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, X_HOLD, 1'b1, 8'hAD, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, X_HOLD, 1'b1, 8'hAD, 1'b0, 8'h00};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, X_ADDR, 1'b1, 8'hAD, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, X_MEM,  1'b1, 8'hAD, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, X_INC,  1'b1, 8'h3C, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 8'h67, X_HOLD, 1'b1, 8'h3C, 1'b0, 8'h00};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 8'h67, X_JUMP, 1'b1, 8'h3C, 1'b1, 8'h67};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 8'h00, X_ADDR, 1'b0, 8'h00, 1'b1, 8'h03};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 8'h00, X_MEM,  1'b0, 8'h00, 1'b1, 8'h5A};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 8'h00, X_INC,  1'b1, 8'h5A, 1'b0, 8'h00};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 8'h00, X_HOLD, 1'b1, 8'h5A, 1'b0, 8'h00};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 8'h00, X_IDLE, 1'b1, 8'h5A, 1'b0, 8'h00};
    // tbl[13]/[14] data: after the jump the PC model holds 'h67, so ADDR puts 'h67 on the bus.
    tbl[13].exp_data = 8'h67;

    #5 reset = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_strobes", i, strb[i], X_IDLE);
      chk("reset_ir", i, ir_s[i], 8'h00);
    end

`ifndef FETCH_STEP_EN
    // Release with run held: both start fetching on the first posedge.
    reset = 1'b1;
    @(posedge clk); #1;
    chk("first_addr", 0, strb[0], X_ADDR);
    chk("first_addr", 1, strb[1], X_ADDR);
    @(negedge clk);
    run = 1'b0;
    ir_ready = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cnt_a += int'(strb[1][1]);
      cnt_b += int'(strb[0][0]);
    end
    chk("ws2_mem_cycles", 1, 8'(cnt_a), 8'd3);
    chk("ir_valid_cycles", 0, 8'(cnt_b), 8'd1);
    chk("single_ir", 0, ir_s[0], 8'hBF);
    chk("single_pc", 0, pc_s[0], 8'h01);
    chk("wrap_ir", 1, ir_s[1], 8'hE1);
    chk("wrap_pc", 1, pc_s[1], 8'h00);

    for (int i = 0; i < 18; i++) begin
      run = tbl[i].run;
      ir_ready = tbl[i].rdy;
      jump_req = tbl[i].jreq;
      jump_addr = tbl[i].jaddr;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_strb", i), 0, strb[0], tbl[i].exp_strb);
      if (tbl[i].chk_ir) chk($sformatf("tbl%0d_ir", i), 0, ir_s[0], tbl[i].exp_ir);
      if (tbl[i].chk_data) chk($sformatf("tbl%0d_data", i), 0, data_s[0], tbl[i].exp_data);
      @(negedge clk);
    end
    chk("after_jump_pc", 0, pc_s[0], 8'h68);
`else
    run = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("step_idle", 0, strb[0], X_IDLE);
    chk("step_idle", 1, strb[1], X_IDLE);
    @(negedge clk);
    ir_ready = 1'b1;
    step = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt_a += int'(strb[0] == X_ADDR);
      cnt_b += int'(strb[1] == X_ADDR);
    end
    step = 1'b0;
    chk("step_held_fetches", 0, 8'(cnt_a), 8'd1);
    chk("step_held_fetches", 1, 8'(cnt_b), 8'd1);
    repeat (4) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    cnt_a = int'(strb[0] == X_ADDR);
    cnt_b = int'(strb[1] == X_ADDR);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      cnt_a += int'(strb[0] == X_ADDR);
      cnt_b += int'(strb[1] == X_ADDR);
    end
    chk("step_pulse_fetches", 0, 8'(cnt_a), 8'd1);
    chk("step_pulse_fetches", 1, 8'(cnt_b), 8'd1);
    chk("step_ir", 0, ir_s[0], 8'hAD);
    chk("step_ir", 1, ir_s[1], 8'hBF);
`endif

    // Randomized traffic, checked every cycle by the reference model.
    cnt_c = 0;
    cnt_d = 0;
    for (int i = 0; i < 3000; i++) begin
      run = ($urandom_range(9) != 0);
      ir_ready = ($urandom_range(9) < 7);
      jump_req = ($urandom_range(7) == 0);
      jump_addr = 8'($urandom);
      step = ($urandom_range(3) == 0);
      @(negedge clk);
      cnt_c += int'(strb[1] == X_INC);
      cnt_d += int'(strb[0] == X_INC);
    end
`ifndef FETCH_STEP_EN
    chk("ws2_fetch_count_ge200", 1, 8'(cnt_c >= 200), 8'd1);
`endif
    $display("random phase: inst0 %0d fetches, inst1 %0d fetches", cnt_d, cnt_c);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
